// File: rtl/result_collector.sv
// Result collector: frames inference-core output bytes, buffers them in a FIFO and streams them to the host.
// Optional running-argmax per frame is enabled by defining RESULT_ARGMAX_EN.
module result_collector #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int FRAME_LEN = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_flag,
   output logic [DATA_W-1:0]            m_data,
   output logic                         m_last,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         frame_done,
   output logic                         overflow,
   output logic [$clog2(FRAME_LEN)-1:0] argmax_idx,
   output logic                         argmax_valid
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN-1);

   logic [DATA_W:0]   r_mem [DEPTH];
   logic [AW:0]       r_wrPtr;
   logic [AW:0]       r_rdPtr;
   logic [IW-1:0]     r_frameIdx;
   logic              r_frameDone;
   logic              r_overflow;

   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [IW-1:0]     w_idx;
   logic              w_isLast;
   logic [DATA_W:0]   w_head;

   // A concurrent clr makes the incoming byte the first of a fresh frame.
   assign w_idx    = clr ? '0 : r_frameIdx;
   assign w_isLast = (w_idx == LAST_IDX);

   assign w_empty = (r_wrPtr == r_rdPtr);
   assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_pop   = !w_empty && m_ready;
   assign w_push  = in_flag && (!w_full || w_pop);
   assign w_drop  = in_flag && w_full && !w_pop;
   assign w_head  = r_mem[r_rdPtr[AW-1:0]];

   assign m_valid    = !w_empty;
   assign m_data     = w_empty ? '0 : w_head[DATA_W-1:0];
   assign m_last     = w_empty ? 1'b0 : w_head[DATA_W];
   assign level      = LW'(r_wrPtr - r_rdPtr);
   assign frame_done = r_frameDone;
   assign overflow   = r_overflow;

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[r_wrPtr[AW-1:0]] <= {w_isLast, in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
      end
   end

   // Frame index advances on every flagged byte, dropped or not, to stay aligned with the core.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frameIdx  <= '0;
         r_frameDone <= 1'b0;
      end else begin
         r_frameDone <= in_flag && w_isLast;
         if (in_flag) begin
            r_frameIdx <= w_isLast ? '0 : w_idx + 1'b1;
         end else if (clr) begin
            r_frameIdx <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

`ifdef RESULT_ARGMAX_EN
   logic signed [DATA_W-1:0] r_maxVal;
   logic [IW-1:0]            r_maxIdx;
   logic [IW-1:0]            r_argIdx;
   logic                     r_argValid;
   logic                     w_take;
   logic [IW-1:0]            w_winIdx;

   // Strictly-greater replacement keeps the lower index on ties.
   assign w_take   = (w_idx == '0) || ($signed(in_data) > r_maxVal);
   assign w_winIdx = w_take ? w_idx : r_maxIdx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_maxVal   <= '0;
         r_maxIdx   <= '0;
         r_argIdx   <= '0;
         r_argValid <= 1'b0;
      end else begin
         r_argValid <= in_flag && w_isLast;
         if (in_flag && w_take) begin
            r_maxVal <= $signed(in_data);
            r_maxIdx <= w_idx;
         end
         if (in_flag && w_isLast) begin
            r_argIdx <= w_winIdx;
         end
      end
   end

   assign argmax_idx   = r_argIdx[$clog2(FRAME_LEN)-1:0];
   assign argmax_valid = r_argValid;
`else
   assign argmax_idx   = '0;
   assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Testbench for result_collector: directed table, hand-written corner sequences and randomized traffic
// checked against a queue-based reference model.
module tb_result_collector;

   localparam int DATA_W    = 8;
   localparam int DEPTH     = 8;
   localparam int FRAME_LEN = 3;
   localparam int LW        = $clog2(DEPTH+1);
   localparam int IW        = $clog2(FRAME_LEN);
`ifdef RESULT_ARGMAX_EN
   localparam bit AM_EN = 1'b1;
`else
   localparam bit AM_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clr = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_flag = 1'b0;
   logic              m_ready = 1'b0;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic              m_valid;
   logic [LW-1:0]     level;
   logic              frame_done;
   logic              overflow;
   logic [IW-1:0]     argmax_idx;
   logic              argmax_valid;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DATA_W:0]          mQ[$];
   bit                       mOvf;
   int                       mIdx;
   bit                       mFd;
   bit                       mAv;
   int                       mAmax;
   logic signed [DATA_W-1:0] mVals[FRAME_LEN];

   result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_flag(in_flag),
      .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
      .level(level), .frame_done(frame_done), .overflow(overflow),
      .argmax_idx(argmax_idx), .argmax_valid(argmax_valid)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advances the model by one clock edge using the inputs currently applied.
   task automatic modelStep(input bit r, input bit c, input bit f, input logic [DATA_W-1:0] d, input bit rd);
      int useIdx;
      int best;
      bit popNow;
      bit isLast;
      if (r) begin
         mQ.delete();
         mOvf = 0; mIdx = 0; mFd = 0; mAv = 0; mAmax = 0;
         return;
      end
      popNow = (mQ.size() > 0) && rd;
      useIdx = c ? 0 : mIdx;
      mFd = 0;
      mAv = 0;
      if (popNow) void'(mQ.pop_front());
      if (f) begin
         isLast = (useIdx == FRAME_LEN-1);
         mVals[useIdx] = d;
         if (mQ.size() < DEPTH) mQ.push_back({isLast, d});
         else if (!c) mOvf = 1;
         if (isLast) begin
            mFd = 1;
            if (AM_EN) begin
               best = 0;
               for (int i = 1; i < FRAME_LEN; i++) if (mVals[i] > mVals[best]) best = i;
               mAmax = best;
               mAv = 1;
            end
         end
         mIdx = isLast ? 0 : useIdx + 1;
      end else if (c) begin
         mIdx = 0;
      end
      if (c) mOvf = 0;
   endtask

   task automatic checkOutput();
      checkVal("m_valid", int'(m_valid), int'(mQ.size() != 0));
      checkVal("m_data", int'(m_data), (mQ.size() != 0) ? int'(mQ[0][DATA_W-1:0]) : 0);
      checkVal("m_last", int'(m_last), (mQ.size() != 0) ? int'(mQ[0][DATA_W]) : 0);
      checkVal("level", int'(level), mQ.size());
      checkVal("frame_done", int'(frame_done), int'(mFd));
      checkVal("overflow", int'(overflow), int'(mOvf));
      checkVal("argmax_idx", int'(argmax_idx), mAmax);
      checkVal("argmax_valid", int'(argmax_valid), int'(mAv));
   endtask

   task automatic applyStimulus(input bit r, input bit c, input bit f, input logic [DATA_W-1:0] d, input bit rd);
      rst = r; clr = c; in_flag = f; in_data = d; m_ready = rd;
      @(posedge clk);
      modelStep(r, c, f, d, rd);
      #1;
      checkOutput();
   endtask

   typedef struct {
      bit                r, c, f;
      logic [DATA_W-1:0] d;
      bit                rd;
      bit                eValid;
      logic [DATA_W-1:0] eData;
      bit                eLast;
      int                eLevel;
      bit                eFd;
      bit                eOvf;
   } vec_t;

   vec_t tbl[8];

   initial begin
      bit rdBias;
      tbl[0] = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0};
      tbl[1] = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0};
      tbl[2] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0};
      tbl[3] = '{0, 0, 1, 8'h11, 1, 1, 8'h11, 0, 1, 0, 0};
      tbl[4] = '{0, 0, 1, 8'h22, 1, 1, 8'h22, 0, 1, 0, 0};
      tbl[5] = '{0, 0, 1, 8'h33, 1, 1, 8'h33, 1, 1, 1, 0};
      tbl[6] = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0};
      tbl[7] = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0};

      for (int i = 0; i < 8; i++) begin
         applyStimulus(tbl[i].r, tbl[i].c, tbl[i].f, tbl[i].d, tbl[i].rd);
         checkVal("tbl_valid", int'(m_valid), int'(tbl[i].eValid));
         checkVal("tbl_data", int'(m_data), int'(tbl[i].eData));
         checkVal("tbl_last", int'(m_last), int'(tbl[i].eLast));
         checkVal("tbl_level", int'(level), tbl[i].eLevel);
         checkVal("tbl_frame_done", int'(frame_done), int'(tbl[i].eFd));
         checkVal("tbl_overflow", int'(overflow), int'(tbl[i].eOvf));
      end

      // Overflow: nine bytes into eight entries, then drain
      applyStimulus(1, 0, 0, 8'h00, 0);
      for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 8'(8'h40 + i), 0);
      checkVal("ovf_level", int'(level), 8);
      checkVal("ovf_set", int'(overflow), 1);
      for (int i = 0; i < 8; i++) begin
         checkVal("drain_data", int'(m_data), 8'h40 + i);
         applyStimulus(0, 0, 0, 8'h00, 1);
         checkVal("drain_ovf_sticky", int'(overflow), 1);
      end
      checkVal("drain_empty", int'(m_valid), 0);
      applyStimulus(0, 1, 0, 8'h00, 0);
      checkVal("clr_ovf", int'(overflow), 0);

      // Full FIFO with simultaneous push and pop
      applyStimulus(1, 0, 0, 8'h00, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 8'(8'h50 + i), 0);
      checkVal("full_level", int'(level), 8);
      applyStimulus(0, 0, 1, 8'hAA, 1);
      checkVal("pushpop_level", int'(level), 8);
      checkVal("pushpop_ovf", int'(overflow), 0);
      checkVal("pushpop_head", int'(m_data), 8'h51);
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 8'h00, 1);

      // Argmax frames (signed compare, ties keep lower index)
      applyStimulus(1, 0, 0, 8'h00, 0);
      applyStimulus(0, 0, 1, 8'h05, 1);
      applyStimulus(0, 0, 1, 8'hF0, 1);
      applyStimulus(0, 0, 1, 8'h05, 1);
      checkVal("am1_valid", int'(argmax_valid), AM_EN ? 1 : 0);
      checkVal("am1_idx", int'(argmax_idx), 0);
      applyStimulus(0, 0, 1, 8'h80, 1);
      applyStimulus(0, 0, 1, 8'h7F, 1);
      applyStimulus(0, 0, 1, 8'h01, 1);
      checkVal("am2_done", int'(frame_done), 1);
      checkVal("am2_idx", int'(argmax_idx), AM_EN ? 1 : 0);
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkVal("am2_pulse_end", int'(argmax_valid), 0);

      // Reset mid-frame discards the partial frame
      applyStimulus(1, 0, 0, 8'h00, 0);
      applyStimulus(0, 0, 1, 8'hB1, 0);
      applyStimulus(0, 0, 1, 8'hB2, 0);
      applyStimulus(1, 0, 0, 8'h00, 0);
      applyStimulus(0, 0, 1, 8'hC1, 0);
      applyStimulus(0, 0, 1, 8'hC2, 0);
      applyStimulus(0, 0, 1, 8'hC3, 0);
      checkVal("rstmid_level", int'(level), 3);
      checkVal("rstmid_head", int'(m_data), 8'hC1);
      checkVal("rstmid_last0", int'(m_last), 0);
      applyStimulus(0, 0, 0, 8'h00, 1);
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkVal("rstmid_third", int'(m_data), 8'hC3);
      checkVal("rstmid_last", int'(m_last), 1);

      // Randomized traffic against the model
      applyStimulus(1, 0, 0, 8'h00, 0);
      rdBias = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) rdBias = ~rdBias;
         applyStimulus($urandom_range(0, 199) == 0,
                       $urandom_range(0, 59) == 0,
                       $urandom_range(0, 3) != 0,
                       8'($urandom),
                       rdBias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
